// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check applied at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Unsigned loads have no store counterpart, so they are illegal with we=1.
    function automatic logic lsu_req_err(input logic        we,
                                         input logic [2:0]  f3,
                                         input logic [31:0] addr,
                                         input int unsigned depth);
        logic bad_f3;
        logic misal;
        logic oor;
        bad_f3 = 1'b0;
        misal  = 1'b0;
        case (f3)
            F3_B:    bad_f3 = 1'b0;
            F3_H:    misal  = addr[0];
            F3_W:    misal  = |addr[1:0];
            F3_BU:   bad_f3 = we;
            F3_HU: begin
                bad_f3 = we;
                misal  = addr[0];
            end
            default: bad_f3 = 1'b1;
        endcase
        oor = ({2'b00, addr[31:2]} >= depth);
        return bad_f3 | misal | oor;
    endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// Lane logic for the load/store unit: load extraction/extension and the
// byte/halfword merge used by the store read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_ext,
    output logic [31:0] o_store_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_load_ext = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_ext = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_ext = i_word;
            F3_BU:   o_load_ext = {24'd0, w_byte};
            F3_HU:   o_load_ext = {16'd0, w_half};
            default: o_load_ext = 32'd0;
        endcase
    end

    always_comb begin
        o_store_merged = i_word;
        case (i_funct3)
            F3_B: begin
                case (i_addr)
                    2'd0:    o_store_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_store_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_store_merged[23:16] = i_wdata[7:0];
                    default: o_store_merged[31:24] = i_wdata[7:0];
                endcase
            end
            F3_H: begin
                if (i_addr[1]) o_store_merged[31:16] = i_wdata[15:0];
                else           o_store_merged[15:0]  = i_wdata[15:0];
            end
            default: o_store_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Multi-cycle load/store unit driving a word-only data memory; sub-word
// stores become an aligned read-modify-write.
//   state | meaning
//   IDLE  | ready, latch request and legality on accept
//   READ  | aligned word read, extract load data or merge store data
//   WRITE | one aligned full-word write
//   RESP  | one-cycle response pulse
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_dataW,
    output logic        o_mem_MemRW,
    input  logic [31:0] i_mem_dataR
);

    lsu_state_t  r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_err;
    logic [31:0] w_load_ext;
    logic [31:0] w_store_merged;

    assign w_err = lsu_req_err(i_req_we, i_req_funct3, i_req_addr, DEPTH_WORDS);

    lsu_align u_align (
        .i_word         (i_mem_dataR),
        .i_addr         (r_addr[1:0]),
        .i_funct3       (r_funct3),
        .i_wdata        (r_wdata),
        .o_load_ext     (w_load_ext),
        .o_store_merged (w_store_merged)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_word   <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we     <= i_req_we;
                        r_funct3 <= i_req_funct3;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                        r_word   <= i_req_wdata;
                        r_rdata  <= 32'd0;
                        r_err    <= w_err;
                        if (w_err)
                            r_state <= RESP;
                        else if (i_req_we && (i_req_funct3 == F3_W))
                            r_state <= WRITE;
                        else
                            r_state <= READ;
                    end
                end
                READ: begin
                    if (r_we) begin
                        r_word  <= w_store_merged;
                        r_state <= WRITE;
                    end else begin
                        r_rdata <= w_load_ext;
                        r_state <= RESP;
                    end
                end
                WRITE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_rdata = (r_state == RESP) ? r_rdata : 32'd0;
    assign o_rsp_err   = (r_state == RESP) ? r_err : 1'b0;

    // Gating with reset keeps a reset landing in WRITE from committing a word.
    assign o_mem_MemRW = (r_state == WRITE) && !i_rst;
    assign o_mem_addr  = ((r_state == READ) || (r_state == WRITE)) ? {r_addr[31:2], 2'b00} : 32'd0;
    assign o_mem_dataW = (r_state == WRITE) ? r_word : 32'd0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed and randomized bench for lsu_mem_master against a word-array
// reference memory with arithmetic load/store semantics.
module tb_lsu_mem_master;

    localparam int DEPTH = 1024;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_dataW;
    logic        o_mem_MemRW;
    logic [31:0] i_mem_dataR;

    always #5 i_clk = ~i_clk;

    lsu_mem_master #(.DEPTH_WORDS(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_dataW  (o_mem_dataW),
        .o_mem_MemRW  (o_mem_MemRW),
        .i_mem_dataR  (i_mem_dataR)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    int          wr_cnt = 0;
    int          rsp_cnt = 0;
    int          align_bad = 0;

    assign i_mem_dataR = mem[o_mem_addr[11:2]];

    always @(posedge i_clk) begin
        if (o_mem_MemRW) begin
            wr_cnt = wr_cnt + 1;
            if (o_mem_addr[1:0] != 2'b00) align_bad = align_bad + 1;
            mem[o_mem_addr[11:2]] <= o_mem_dataW;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
        if (o_rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          last_wr;
    logic        last_busy_ok;
    int          n_txn = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- reference model: plain arithmetic on byte addresses ----
    function automatic int access_size(input logic [2:0] f3);
        case (f3)
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 1;
        endcase
    endfunction

    function automatic logic exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int size;
        size  = access_size(f3);
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
        return !legal || ((a % size) != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v;
        int shift;
        shift = (a % 4) * 8;
        v = word >> shift;
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] mask;
        int size;
        int shift;
        size  = access_size(f3);
        shift = (a % 4) * 8;
        if (size == 4) mask = 32'hFFFF_FFFF;
        else           mask = ((32'd1 << (8 * size)) - 32'd1) << shift;
        return (old & ~mask) | ((wd << shift) & mask);
    endfunction

    task automatic poke(input int idx, input logic [31:0] data);
        pre_idx  = idx[9:0];
        pre_data = data;
        pre_we   = 1'b1;
        ref_mem[idx] = data;
        @(negedge i_clk);
        pre_we = 1'b0;
    endtask

    // Starts and ends at a falling edge; request held until the response.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int w0;
        int guard;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = wd;
        i_req_valid  = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 10) begin
            @(negedge i_clk);
            guard++;
        end
        w0 = wr_cnt;
        @(posedge i_clk);
        last_busy_ok = 1'b1;
        last_lat     = 0;
        last_rdata   = 32'd0;
        last_err     = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            if (o_req_ready) last_busy_ok = 1'b0;
            if (o_rsp_valid) begin
                last_lat   = k;
                last_rdata = o_rsp_rdata;
                last_err   = o_rsp_err;
                break;
            end
        end
        i_req_valid = 1'b0;
        last_wr = wr_cnt - w0;
        n_txn++;
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        logic [31:0] er;
        int          elat;
        int          ewr;
        int          idx;
        e    = exp_err(we, f3, a);
        idx  = int'(a / 4) % DEPTH;
        er   = (e || we) ? 32'd0 : exp_load(f3, a, ref_mem[idx]);
        elat = e ? 1 : ((we && f3 != 3'd2) ? 3 : 2);
        ewr  = (we && !e) ? 1 : 0;
        txn(we, f3, a, wd);
        check({tag, "/err"},   32'(last_err), 32'(e));
        check({tag, "/rdata"}, last_rdata, er);
        check({tag, "/lat"},   32'(last_lat), 32'(elat));
        check({tag, "/writes"}, 32'(last_wr), 32'(ewr));
        check({tag, "/busy"},  32'(last_busy_ok), 32'd1);
        if (we && !e) ref_mem[idx] = exp_store(f3, a, ref_mem[idx], wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        we;
        int          rsp0;
        int          wr0;

        i_rst        = 1'b1;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'd2;
        i_req_addr   = 32'h10;
        i_req_wdata  = 32'd0;

        @(negedge i_clk);
        for (int i = 0; i < 64; i++) poke(i, $urandom);

        check("reset/ready",  32'(o_req_ready), 32'd1);
        check("reset/rsp",    32'(o_rsp_valid), 32'd0);
        check("reset/rdata",  o_rsp_rdata, 32'd0);
        check("reset/err",    32'(o_rsp_err), 32'd0);
        check("reset/maddr",  o_mem_addr, 32'd0);
        check("reset/mdata",  o_mem_dataW, 32'd0);
        check("reset/memrw",  32'(o_mem_MemRW), 32'd0);

        i_req_valid = 1'b0;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_reset/ready", 32'(o_req_ready), 32'd1);
        check("post_reset/rsps",  32'(rsp_cnt), 32'd0);

        poke(4, 32'h8081_F2F3);
        run("LB13", 1'b0, 3'b000, 32'h13, 32'd0);
        check("LB13/const", last_rdata, 32'hFFFF_FF80);
        run("LBU13", 1'b0, 3'b100, 32'h13, 32'd0);
        check("LBU13/const", last_rdata, 32'h0000_0080);
        run("LH10", 1'b0, 3'b001, 32'h10, 32'd0);
        check("LH10/const", last_rdata, 32'hFFFF_F2F3);
        run("LHU12", 1'b0, 3'b101, 32'h12, 32'd0);
        check("LHU12/const", last_rdata, 32'h0000_8081);

        @(negedge i_clk);
        poke(4, 32'h1122_3344);
        run("SB11", 1'b1, 3'b000, 32'h11, 32'h0000_00AA);
        @(negedge i_clk);
        check("SB11/mem", mem[4], 32'h1122_AA44);

        run("SW20", 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
        run("LW20", 1'b0, 3'b010, 32'h20, 32'd0);
        check("LW20/const", last_rdata, 32'hDEAD_BEEF);

        run("ERR_LW22",   1'b0, 3'b010, 32'h22, 32'd0);
        run("ERR_SH31",   1'b1, 3'b001, 32'h31, 32'h1234);
        run("ERR_LW_oor", 1'b0, 3'b010, 32'(4 * DEPTH), 32'd0);
        run("ERR_F3_011", 1'b0, 3'b011, 32'h40, 32'd0);
        run("ERR_SBU",    1'b1, 3'b100, 32'h40, 32'h55);

        // Reset while the SH write is on the bus: no commit, no response.
        @(negedge i_clk);
        poke(5, 32'h5566_7788);
        rsp0 = rsp_cnt;
        wr0  = wr_cnt;
        i_req_we = 1'b1; i_req_funct3 = 3'b001; i_req_addr = 32'h16; i_req_wdata = 32'h0000_1234;
        i_req_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_wr/in_write", 32'(o_mem_MemRW), 32'd1);
        i_rst = 1'b1;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_wr/ready", 32'(o_req_ready), 32'd1);
        check("rst_wr/rsp",   32'(o_rsp_valid), 32'd0);
        repeat (3) @(negedge i_clk);
        check("rst_wr/mem",    mem[5], 32'h5566_7788);
        check("rst_wr/writes", 32'(wr_cnt - wr0), 32'd0);
        check("rst_wr/rsps",   32'(rsp_cnt - rsp0), 32'd0);
        rsp0 = rsp_cnt - n_txn;

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 15) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
            else                            a = 32'($urandom_range(0, 255));
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            run("rand", we, f3, a, $urandom);
        end

        @(negedge i_clk);
        for (int i = 0; i < 64; i++) check("final/mem", mem[i], ref_mem[i]);
        check("final/rsp_count", 32'(rsp_cnt - rsp0), 32'(n_txn));
        check("final/align",     32'(align_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
